// File: rtl/gate_ctrl.sv
// Gate-evaluation sequencer: clears the accumulators, walks the X and Y weight
// columns, waits for both dot products, applies the bias, then flags the result.
module gate_ctrl #(
    parameter int INPUT_SZ  = 8,
    parameter int HIDDEN_SZ = 16,
    parameter int AX_W      = $clog2(INPUT_SZ),
    parameter int AY_W      = $clog2(HIDDEN_SZ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            dataReady_X,
    input  logic            dataReady_Y,
    output logic            busy,
    output logic            accClear,
    output logic            macEn_X,
    output logic            macEn_Y,
    output logic [AX_W-1:0] colAddress_X,
    output logic [AY_W-1:0] colAddress_Y,
    output logic            biasEn,
    output logic            dataReady_gate,
    output logic [7:0]      evalCount
);

    localparam int unsigned RUN_LEN = (INPUT_SZ > HIDDEN_SZ) ? INPUT_SZ : HIDDEN_SZ;
    localparam int unsigned CNT_W   = $clog2(RUN_LEN + 1);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] X_LEN    = CNT_W'(INPUT_SZ);
    localparam logic [CNT_W-1:0] Y_LEN    = CNT_W'(HIDDEN_SZ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_WAIT,
        S_BIAS,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             got_x_q, got_x_d;
    logic             got_y_q, got_y_d;

    logic             busy_q, busy_d;
    logic             acc_clear_q, acc_clear_d;
    logic             mac_en_x_q, mac_en_x_d;
    logic             mac_en_y_q, mac_en_y_d;
    logic [AX_W-1:0]  col_addr_x_q, col_addr_x_d;
    logic [AY_W-1:0]  col_addr_y_q, col_addr_y_d;
    logic             bias_en_q, bias_en_d;
    logic             gate_ready_q, gate_ready_d;
    logic [7:0]       eval_count_q, eval_count_d;

    logic             both_ready;

    // Ready seen this cycle counts together with the sticky flags, so a late
    // result moves WAIT on at the very edge that samples it.
    assign both_ready = (got_x_q | dataReady_X) & (got_y_q | dataReady_Y);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            got_x_q      <= 1'b0;
            got_y_q      <= 1'b0;
            busy_q       <= 1'b0;
            acc_clear_q  <= 1'b0;
            mac_en_x_q   <= 1'b0;
            mac_en_y_q   <= 1'b0;
            col_addr_x_q <= '0;
            col_addr_y_q <= '0;
            bias_en_q    <= 1'b0;
            gate_ready_q <= 1'b0;
            eval_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            got_x_q      <= got_x_d;
            got_y_q      <= got_y_d;
            busy_q       <= busy_d;
            acc_clear_q  <= acc_clear_d;
            mac_en_x_q   <= mac_en_x_d;
            mac_en_y_q   <= mac_en_y_d;
            col_addr_x_q <= col_addr_x_d;
            col_addr_y_q <= col_addr_y_d;
            bias_en_q    <= bias_en_d;
            gate_ready_q <= gate_ready_d;
            eval_count_q <= eval_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        got_x_d = got_x_q;
        got_y_d = got_y_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                got_x_d = 1'b0;
                got_y_d = 1'b0;
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                got_x_d = got_x_q | dataReady_X;
                got_y_d = got_y_q | dataReady_Y;
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                got_x_d = got_x_q | dataReady_X;
                got_y_d = got_y_q | dataReady_Y;
                if (both_ready) state_d = S_BIAS;
            end
            S_BIAS:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up
    // with the state they describe.
    always_comb begin
        busy_d       = (state_d != S_IDLE);
        acc_clear_d  = 1'b0;
        mac_en_x_d   = 1'b0;
        mac_en_y_d   = 1'b0;
        col_addr_x_d = '0;
        col_addr_y_d = '0;
        bias_en_d    = 1'b0;
        gate_ready_d = 1'b0;
        eval_count_d = eval_count_q;
        unique case (state_d)
            S_CLEAR: acc_clear_d = 1'b1;
            S_RUN: begin
                mac_en_x_d   = (cnt_d < X_LEN);
                mac_en_y_d   = (cnt_d < Y_LEN);
                col_addr_x_d = (cnt_d < X_LEN) ? AX_W'(cnt_d) : AX_W'(INPUT_SZ - 1);
                col_addr_y_d = (cnt_d < Y_LEN) ? AY_W'(cnt_d) : AY_W'(HIDDEN_SZ - 1);
            end
            S_BIAS: bias_en_d = 1'b1;
            S_DONE: begin
                gate_ready_d = 1'b1;
                eval_count_d = eval_count_q + 8'd1;
            end
            default: ;
        endcase
    end

    assign busy           = busy_q;
    assign accClear       = acc_clear_q;
    assign macEn_X        = mac_en_x_q;
    assign macEn_Y        = mac_en_y_q;
    assign colAddress_X   = col_addr_x_q;
    assign colAddress_Y   = col_addr_y_q;
    assign biasEn         = bias_en_q;
    assign dataReady_gate = gate_ready_q;
    assign evalCount      = eval_count_q;

endmodule

// File: tb/tb_gate_ctrl.sv
// Scoreboard bench for gate_ctrl: default instance (8/16) and a swapped-size
// instance (16/8); expected pulses and addresses are queued, a monitor pops them.
module tb_gate_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [1:0] start_v, rdx_v, rdy_v;

    logic       busy0, acc0, mx0, my0, bias0, drg0;
    logic       busy1, acc1, mx1, my1, bias1, drg1;
    logic [2:0] cax0;
    logic [3:0] cay0;
    logic [3:0] cax1;
    logic [2:0] cay1;
    logic [7:0] ev0, ev1;

    gate_ctrl u_dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]),
        .dataReady_X(rdx_v[0]), .dataReady_Y(rdy_v[0]),
        .busy(busy0), .accClear(acc0), .macEn_X(mx0), .macEn_Y(my0),
        .colAddress_X(cax0), .colAddress_Y(cay0),
        .biasEn(bias0), .dataReady_gate(drg0), .evalCount(ev0)
    );

    gate_ctrl #(.INPUT_SZ(16), .HIDDEN_SZ(8)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]),
        .dataReady_X(rdx_v[1]), .dataReady_Y(rdy_v[1]),
        .busy(busy1), .accClear(acc1), .macEn_X(mx1), .macEn_Y(my1),
        .colAddress_X(cax1), .colAddress_Y(cay1),
        .biasEn(bias1), .dataReady_gate(drg1), .evalCount(ev1)
    );

    logic [1:0] busy_w, acc_w, mx_w, my_w, bias_w, drg_w;
    assign busy_w = {busy1, busy0};
    assign acc_w  = {acc1, acc0};
    assign mx_w   = {mx1, mx0};
    assign my_w   = {my1, my0};
    assign bias_w = {bias1, bias0};
    assign drg_w  = {drg1, drg0};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Entries carry the instance index in their low bit (or top bit for run_q).
    logic [18:0] run_q[$];
    int          clr_q[$];
    int          bias_q[$];
    int          ev_q[$];
    int          ev_m[2];
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  m_ax, m_ay, m_ev;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic spurious(input string name);
        checks++;
        errors++;
        $display("FAIL %s: actual=pulse required=none (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                m_ax = 8'(cax0); m_ay = 8'(cay0); m_ev = ev0;
            end else begin
                m_ax = 8'(cax1); m_ay = 8'(cay1); m_ev = ev1;
            end
            if (acc_w[i]) begin
                if (clr_q.size() == 0) spurious("accClear");
                else check("accClear_cycle", cyc * 2 + i, clr_q.pop_front());
            end
            if (mx_w[i] | my_w[i]) begin
                if (run_q.size() == 0) spurious("mac_enable");
                else check("mac_addr", 32'({i[0], mx_w[i], my_w[i], m_ax, m_ay}),
                           32'(run_q.pop_front()));
            end else if (busy_w[i]) begin
                check("addr_zero", 32'({m_ax, m_ay}), 0);
            end
            if (bias_w[i]) begin
                if (bias_q.size() == 0) spurious("biasEn");
                else check("biasEn_cycle", cyc * 2 + i, bias_q.pop_front());
            end
            if (drg_w[i]) begin
                if (ev_q.size() == 0) spurious("dataReady_gate");
                else check("gate_cycle_count", (cyc * 256 + 32'(m_ev)) * 2 + i, ev_q.pop_front());
            end
        end
    end

    // Queue the full expected response of one evaluation sampled at edge s,
    // with the WAIT decision made in cycle d.
    task automatic push_eval(input int inst, input int s, input int d, input int n_run);
        int is, hs;
        is = (inst == 0) ? 8 : 16;
        hs = (inst == 0) ? 16 : 8;
        clr_q.push_back(s * 2 + inst);
        for (int k = 0; k < n_run; k++)
            run_q.push_back({inst[0], (k < is), (k < hs),
                             8'((k < is) ? k : is - 1), 8'((k < hs) ? k : hs - 1)});
        if (n_run == 16) begin
            ev_m[inst] = (ev_m[inst] + 1) % 256;
            bias_q.push_back((d + 1) * 2 + inst);
            ev_q.push_back(((d + 2) * 256 + ev_m[inst]) * 2 + inst);
        end
    endtask

    // One evaluation; ready pulses at offsets from the start-sampling edge,
    // optional start toggling while busy (including the DONE cycle).
    task automatic run_eval(input int inst, input int tx_off, input int ty_off, input bit tog);
        int s, d;
        s = cyc + 1;
        d = s + 17;
        if (s + tx_off > d) d = s + tx_off;
        if (s + ty_off > d) d = s + ty_off;
        start_v[inst] = 1'b1;
        push_eval(inst, s, d, 16);
        @(negedge clk);
        while (cyc < d + 3) begin
            start_v[inst] = tog && cyc[0];
            rdx_v[inst]   = (cyc == s + tx_off);
            rdy_v[inst]   = (cyc == s + ty_off);
            @(negedge clk);
        end
        start_v[inst] = 1'b0;
        rdx_v[inst]   = 1'b0;
        rdy_v[inst]   = 1'b0;
        check("idle_after_eval", 32'(busy_w[inst]), 0);
    endtask

    task automatic b2b(input int n);
        int s;
        s = cyc + 1;
        start_v[0] = 1'b1;
        rdx_v[0]   = 1'b1;
        rdy_v[0]   = 1'b1;
        for (int j = 0; j < n; j++) push_eval(0, s + 21 * j, s + 21 * j + 17, 16);
        while (cyc < s + 21 * (n - 1) + 20) @(negedge clk);
        start_v[0] = 1'b0;
        rdx_v[0]   = 1'b0;
        rdy_v[0]   = 1'b0;
        @(negedge clk);
        check("idle_after_b2b", 32'(busy0), 0);
        check("evalCount_wrap", 32'(ev0), 0);
    endtask

    initial begin
        int s;
        reset   = 1'b0;
        start_v = '0;
        rdx_v   = '0;
        rdy_v   = '0;
        ev_m[0] = 0;
        ev_m[1] = 0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'({busy1, busy0}), 0);
        check("reset_pulses", 32'({acc_w, mx_w, my_w, bias_w, drg_w}), 0);
        check("reset_addr", 32'({cax0, cay0, cax1, cay1}), 0);
        check("reset_evalCount", 32'({ev1, ev0}), 0);
        reset = 1'b1;
        @(negedge clk);

        run_eval(0, 16, 16, 1'b0);
        run_eval(0, 25, 20, 1'b0);
        run_eval(0, 19, 19, 1'b1);
        run_eval(0, 3, 5, 1'b0);
        run_eval(1, 16, 16, 1'b0);

        // Asynchronous abort in the cycle showing colAddress_Y = 9.
        s = cyc + 1;
        start_v[0] = 1'b1;
        push_eval(0, s, 0, 9);
        @(negedge clk);
        start_v[0] = 1'b0;
        while (cyc < s + 9) @(negedge clk);
        @(posedge clk);
        #1;
        check("addr_before_abort", 32'(cay0), 9);
        #1 reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy0), 0);
        check("abort_pulses", 32'({acc0, mx0, my0, bias0, drg0}), 0);
        check("abort_addr", 32'({cax0, cay0}), 0);
        check("abort_evalCount", 32'(ev0), 0);
        ev_m[0] = 0;
        ev_m[1] = 0;
        @(negedge clk);
        reset = 1'b1;
        run_eval(0, 16, 16, 1'b0);

        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        ev_m[0] = 0;
        ev_m[1] = 0;
        b2b(256);

        repeat (5) @(negedge clk);
        check("leftover_run", run_q.size(), 0);
        check("leftover_clear", clr_q.size(), 0);
        check("leftover_bias", bias_q.size(), 0);
        check("leftover_gate", ev_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
